// File: rtl/guess_game_pkg.sv
// Shared encodings and helpers for the switch-guessing game controller:
// FSM state codes, dot-matrix picture codes and the per-level target mask.
package guess_game_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_GREET = 3'd1;
   localparam state_t ST_REQ   = 3'd2;
   localparam state_t ST_PLAY  = 3'd3;
   localparam state_t ST_JUDGE = 3'd4;
   localparam state_t ST_WIN   = 3'd5;
   localparam state_t ST_LOSE  = 3'd6;

   localparam logic [2:0] DZ_BLANK = 3'd0;
   localparam logic [2:0] DZ_GREET = 3'd1;
   localparam logic [2:0] DZ_PLAY  = 3'd2;
   localparam logic [2:0] DZ_WRONG = 3'd3;
   localparam logic [2:0] DZ_WIN   = 3'd4;
   localparam logic [2:0] DZ_LOSE  = 3'd5;

   // Level k keeps the low BASE_W+k-1 bits of the target and the guess.
   function automatic logic [31:0] levelMask(input int baseW, input logic [2:0] lvl);
      int width;
      width = baseW + int'(lvl) - 1;
      if (width >= 32) return '1;
      return (32'd1 << width) - 32'd1;
   endfunction

   function automatic logic [2:0] stateDz(input state_t st);
      case (st)
         ST_GREET: return DZ_GREET;
         ST_REQ:   return DZ_PLAY;
         ST_PLAY:  return DZ_PLAY;
         ST_JUDGE: return DZ_PLAY;
         ST_WIN:   return DZ_WIN;
         ST_LOSE:  return DZ_LOSE;
         default:  return DZ_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Board-side bundle of the game controller: switches, buttons, random handshake
// and the registered display outputs. The controller uses the slave view.
interface guess_game_ctrl_if #(
   parameter int GW = 7
);
   logic          i_en;
   logic          i_restart;
   logic          i_submit;
   logic [GW-1:0] i_guess;
   logic          i_tick;
   logic          o_rand_req;
   logic          i_rand_vld;
   logic [GW-1:0] i_rand_val;
   logic [GW-1:0] o_target_led;
   logic [2:0]    o_level;
   logic [3:0]    o_time_left;
   logic [2:0]    o_tries_left;
   logic [2:0]    o_dz_code;
   logic          o_beep_req;
   logic          o_win;
   logic          o_lose;

   modport master (
      output i_en, i_restart, i_submit, i_guess, i_tick, i_rand_vld, i_rand_val,
      input  o_rand_req, o_target_led, o_level, o_time_left, o_tries_left,
             o_dz_code, o_beep_req, o_win, o_lose
   );

   modport slave (
      input  i_en, i_restart, i_submit, i_guess, i_tick, i_rand_vld, i_rand_val,
      output o_rand_req, o_target_led, o_level, o_time_left, o_tries_left,
             o_dz_code, o_beep_req, o_win, o_lose
   );
endinterface

// File: rtl/guess_game_ctrl_countdown.sv
// Per-level countdown and remaining-tries counters; both saturate at zero.
// o_time_zero flags the tick that takes time_left from 1 to 0.
module game_countdown #(
   parameter int TIME_SEC  = 9,
   parameter int MAX_TRIES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clear,
   input  logic       i_load,
   input  logic       i_tick,
   input  logic       i_dec_try,
   output logic [3:0] o_time_left,
   output logic [2:0] o_tries_left,
   output logic       o_time_zero,
   output logic       o_tries_last
);
   localparam logic [3:0] TIME_INIT  = 4'(TIME_SEC);
   localparam logic [2:0] TRIES_INIT = 3'(MAX_TRIES);
   localparam bit         TIMEOUT_ON = (TIME_SEC != 0);

   logic [3:0] r_time;
   logic [2:0] r_tries;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_time  <= '0;
         r_tries <= '0;
      end else if (i_clear) begin
         r_time  <= '0;
         r_tries <= '0;
      end else if (i_load) begin
         r_time  <= TIME_INIT;
         r_tries <= TRIES_INIT;
      end else begin
         if (i_tick && TIMEOUT_ON && (r_time != 4'd0)) r_time <= r_time - 4'd1;
         if (i_dec_try && (r_tries != 3'd0)) r_tries <= r_tries - 3'd1;
      end
   end

   assign o_time_left  = r_time;
   assign o_tries_left = r_tries;
   assign o_time_zero  = i_tick && TIMEOUT_ON && (r_time == 4'd1);
   assign o_tries_last = (r_tries == 3'd1);

endmodule

// File: rtl/guess_game_ctrl.sv
// Level-based switch-guessing game controller. All board outputs are registered
// from the next-state decision so they line up with the state they describe.
module guess_game_ctrl
   import guess_game_pkg::*;
#(
   parameter int LEVELS    = 3,
   parameter int BASE_W    = 5,
   parameter int TIME_SEC  = 9,
   parameter int MAX_TRIES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   guess_game_ctrl_if.slave bus
);
   localparam int GW = BASE_W + LEVELS - 1;

   state_t        r_state, w_next;
   logic [2:0]    r_level, w_levelNext;
   logic [GW-1:0] r_target, w_targetNext, w_mask;
   logic [GW-1:0] r_targetLed;
   logic [2:0]    r_dzCode;
   logic          r_randReq, r_beepReq, r_win, r_lose;
   logic          w_load, w_decTry, w_beep, w_wrong, w_tickPlay, w_match;
   logic          w_timeZero, w_triesLast;

   assign w_mask       = GW'(levelMask(BASE_W, r_level));
   assign w_match      = ((bus.i_guess & w_mask) == r_target);
   assign w_targetNext = w_load ? (bus.i_rand_val & w_mask) : r_target;
   // A submit or restart in the same cycle pre-empts the tick entirely.
   assign w_tickPlay   = bus.i_en && bus.i_tick && (r_state == ST_PLAY)
                         && !bus.i_restart && !bus.i_submit;

   game_countdown #(
      .TIME_SEC  (TIME_SEC),
      .MAX_TRIES (MAX_TRIES)
   ) u_countdown (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (!bus.i_en),
      .i_load       (w_load),
      .i_tick       (w_tickPlay),
      .i_dec_try    (w_decTry),
      .o_time_left  (bus.o_time_left),
      .o_tries_left (bus.o_tries_left),
      .o_time_zero  (w_timeZero),
      .o_tries_last (w_triesLast)
   );

   always_comb begin
      w_next      = r_state;
      w_levelNext = r_level;
      w_load      = 1'b0;
      w_decTry    = 1'b0;
      w_beep      = 1'b0;
      w_wrong     = 1'b0;
      case (r_state)
         ST_IDLE:  w_next = ST_GREET;
         ST_GREET: if (bus.i_restart) begin w_next = ST_REQ; w_levelNext = 3'd1; end
         ST_REQ:   if (bus.i_rand_vld) begin w_next = ST_PLAY; w_load = 1'b1; end
         ST_PLAY: begin
            if (bus.i_restart) begin
               w_next      = ST_REQ;
               w_levelNext = 3'd1;
            end else if (bus.i_submit) begin
               w_next = ST_JUDGE;
            end else if (w_timeZero) begin
               w_next = ST_LOSE;
               w_beep = 1'b1;
            end
         end
         ST_JUDGE: begin
            if (w_match) begin
               if (r_level == 3'(LEVELS)) begin
                  w_next = ST_WIN;
               end else begin
                  w_next      = ST_REQ;
                  w_levelNext = r_level + 3'd1;
               end
            end else begin
               w_decTry = 1'b1;
               w_beep   = 1'b1;
               w_wrong  = 1'b1;
               w_next   = w_triesLast ? ST_LOSE : ST_PLAY;
            end
         end
         ST_WIN, ST_LOSE: if (bus.i_restart) begin w_next = ST_REQ; w_levelNext = 3'd1; end
         default:  w_next = ST_IDLE;
      endcase
      // The enable switch overrides every other event.
      if (!bus.i_en) begin
         w_next      = ST_IDLE;
         w_levelNext = 3'd0;
         w_load      = 1'b0;
         w_decTry    = 1'b0;
         w_beep      = 1'b0;
         w_wrong     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_level     <= '0;
         r_target    <= '0;
         r_targetLed <= '0;
         r_dzCode    <= DZ_BLANK;
         r_randReq   <= 1'b0;
         r_beepReq   <= 1'b0;
         r_win       <= 1'b0;
         r_lose      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_level     <= w_levelNext;
         r_target    <= bus.i_en ? w_targetNext : '0;
         r_targetLed <= (w_next == ST_PLAY) ? w_targetNext : '0;
         r_dzCode    <= (w_wrong && (w_next == ST_PLAY)) ? DZ_WRONG : stateDz(w_next);
         r_randReq   <= (w_next == ST_REQ);
         r_beepReq   <= w_beep;
         r_win       <= (w_next == ST_WIN);
         r_lose      <= (w_next == ST_LOSE);
      end
   end

   assign bus.o_level      = r_level;
   assign bus.o_target_led = r_targetLed;
   assign bus.o_dz_code    = r_dzCode;
   assign bus.o_rand_req   = r_randReq;
   assign bus.o_beep_req   = r_beepReq;
   assign bus.o_win        = r_win;
   assign bus.o_lose       = r_lose;

endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Parametrised controller for the switch-guessing game.
- Runs a configurable number of levels; each level widens the target by one bit.
- Adds a per-level countdown, a limited number of tries, a random-number handshake and explicit win/lose outcomes.
- Sits between the board inputs (switches and debounced buttons) and the existing random, dot-matrix, beeper and 7-seg modules; all outputs are registered.

Parameters:
LEVELS, 3, number of game levels (1..7)
BASE_W, 5, target width at level 1; level k uses BASE_W+k-1 bits
TIME_SEC, 9, countdown start value in ticks per level; 0 disables timeout
MAX_TRIES, 3, wrong guesses allowed per level (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  game enable switch (level, synchronised upstream)
restart  in  1  single-cycle pulse: start or restart from level 1
submit  in  1  single-cycle pulse: evaluate guess
guess  in  GW  switch value, GW = BASE_W+LEVELS-1
tick  in  1  single-cycle timing strobe (e.g. 1 Hz)
rand_req  out  1  request a new random target
rand_vld  in  1  random value valid
rand_val  in  GW  random value
target_led  out  GW  masked target shown on LEDs during PLAY, else 0
level  out  3  current level 1..LEVELS, 0 when idle
time_left  out  4  countdown value
tries_left  out  3  remaining wrong guesses
dz_code  out  3  matrix picture: 0 blank, 1 greet, 2 play, 3 wrong, 4 win, 5 lose
beep_req  out  1  one-cycle pulse on wrong guess or loss
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
- rst low (async): state IDLE; all outputs 0; target register 0.
- en low in any state: go to IDLE on the next clk and clear all outputs. This has priority over every other event.
- IDLE: if en=1, go to GREET with dz_code=1.
- GREET: restart -> level=1, go to REQ.
- REQ:
  - rand_req=1 from the cycle after entry until rand_vld is sampled high.
  - On rand_vld: latch target = rand_val & mask(level); time_left=TIME_SEC; tries_left=MAX_TRIES; go to PLAY.
  - rand_req=0 from the next cycle.
  - rand_vld outside REQ is ignored.
- PLAY:
  - dz_code=2; target_led=target.
  - On tick with TIME_SEC!=0: time_left decrements; on tick with time_left==1, time_left goes to 0 and the state goes to LOSE.
  - submit -> JUDGE. If submit and timeout occur in the same cycle, submit wins and time_left does not decrement.
  - restart -> level=1, go to REQ.
- JUDGE (exactly 1 cycle):
  - target_led=0.
  - If (guess & mask(level)) == target:
    - level==LEVELS -> WIN.
    - Otherwise level+1 and go to REQ.
  - If not equal:
    - beep_req pulses for 1 cycle, dz_code=3, tries_left decrements.
    - If tries_left was 1 -> LOSE; otherwise back to PLAY. The countdown is not reloaded.
- WIN: win=1, dz_code=4. restart -> level=1, go to REQ.
- LOSE: lose=1, dz_code=5. beep_req pulses once on entry. restart -> level=1, go to REQ.
- mask(level) = (1<<(BASE_W+level-1))-1. Comparison uses only masked bits; upper switch bits are don't-care.
- Latencies:
  - submit to verdict: 2 clk.
  - rand_vld to PLAY: 1 clk.
- Simultaneous restart and submit in PLAY: restart wins.
- time_left saturates at 0 and never wraps. tries_left never underflows.

Decomposition:
- Shared package guess_game_pkg holds:
  - state encodings (IDLE, GREET, REQ, PLAY, JUDGE, WIN, LOSE);
  - dz_code constants;
  - the mask(level) function.
- One sub-module, game_countdown, holds the time_left/tries_left counters. Its interface is load, tick, dec_try, time_zero and tries_last.

Test Plan:
- Reset with en=1 held, then release rst -> IDLE, then GREET next clk; all outputs 0 except dz_code=1.
- restart; rand_val=7'h2B, rand_vld 3 clk later -> rand_req high 3 cycles; target_led=0x0B, time_left=9, tries_left=3. Submit guesses 0x0B, 0x2B, 0x2B (rand 0x2B each level) -> level 1->2->3 -> win=1, dz_code=4.
- Level 1 target 0x0B; submit 0x01 three times -> three beep_req pulses, tries_left 3->2->1, then lose=1, dz_code=5.
- PLAY at level 1 with 9 ticks and no submit -> time_left reaches 0 on the 9th tick, then LOSE; with TIME_SEC=0, 20 ticks -> still PLAY.
- submit and tick in the same cycle with time_left=1 -> JUDGE taken, not LOSE; correct guess advances the level.
- Drop en mid-PLAY at level 2 -> IDLE next clk, level=0, target_led=0; restart while en=0 is ignored.
